wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writes always win; long-latency
// results wait in a FIFO. Optional macro WB_LU_BYPASS_EN lets a result skip an empty queue.
module wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pipe_wen,
  input  logic [4:0]               pipe_wa,
  input  logic [31:0]              pipe_wd,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_wa,
  input  logic [31:0]              lu_wd,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  output logic                     wen,
  output logic [4:0]               wa,
  output logic [31:0]              wd,
  output logic [31:0]              busy_mask,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_busy;

  logic            w_pipe_wr;
  logic            w_empty;
  logic            w_xfer;
  logic            w_byp;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic [31:0]     w_busy_nxt;
  entry_t          w_head;

  assign w_pipe_wr = pipe_wen && (pipe_wa != 5'd0);
  assign w_empty   = (r_count == CW'(0));
  assign lu_ready  = (r_count < CW'(DEPTH));
  assign w_xfer    = lu_valid && lu_ready;
  assign w_head    = r_mem[r_rd_ptr];

`ifdef WB_LU_BYPASS_EN
  assign w_byp = w_xfer && (lu_wa != 5'd0) && !w_pipe_wr && w_empty && !reset;
`else
  assign w_byp = 1'b0;
`endif

  // Zero-destination results are accepted but never stored.
  assign w_push = w_xfer && (lu_wa != 5'd0) && !w_byp;

  // Write-port mux: pipeline, then queue head, then bypassed lu result.
  always_comb begin
    wen   = 1'b0;
    wa    = 5'd0;
    wd    = 32'd0;
    w_pop = 1'b0;
    w_clr = 1'b0;
    if (!reset) begin
      if (w_pipe_wr) begin
        wen = 1'b1;
        wa  = pipe_wa;
        wd  = pipe_wd;
      end else if (!w_empty) begin
        wen   = 1'b1;
        wa    = w_head.wa;
        wd    = w_head.wd;
        w_pop = 1'b1;
        w_clr = 1'b1;
      end else if (w_byp) begin
        wen   = 1'b1;
        wa    = lu_wa;
        wd    = lu_wd;
        w_clr = 1'b1;
      end
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) begin
      w_busy_nxt[wa] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_nxt;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= entry_t'({lu_wa, lu_wd});
    end
  end

  assign busy_mask = r_busy;
  assign q_count   = r_count;

endmodule
